// File: rtl/y_pulse_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y_pulse_meter : measures high-pulse lengths on y_in, queues them in a FWFT FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module y_pulse_meter #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LEN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             y_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_len,
  output logic             m_sat,
  output logic             busy,
  output logic             ovf_sticky
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  state_e           state_q;
  logic             y_q;
  logic             ysmp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             push_q;
  logic [CNT_W:0]   rec_q;

  logic [CNT_W:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             ovf_q;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // ysmp_q marks that y_q holds a real sample, so ARM cannot mistake the
  // reset value of y_q for the end of a pulse that was already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= 1'b0;
      ysmp_q <= 1'b0;
    end else begin
      y_q    <= y_in;
      ysmp_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      push_q  <= 1'b0;
      rec_q   <= '0;
    end else if (clr) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        ST_ARM: begin
          if (ysmp_q && !y_q) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (y_q) begin
            state_q <= ST_COUNT;
            cnt_q   <= CNT_W'(1);
            sat_q   <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (y_q) begin
            if (cnt_q == CNT_MAX) sat_q <= 1'b1;
            else                  cnt_q <= cnt_q + 1'b1;
          end else begin
            state_q <= ST_IDLE;
            push_q  <= sat_q || (cnt_q >= MIN_LEN_C);
            rec_q   <= {sat_q, cnt_q};
          end
        end
        default: state_q <= ST_ARM;
      endcase
    end
  end

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == DEPTH_C);
  assign w_pop   = !w_empty && m_ready;
  assign w_push  = push_q && (!w_full || w_pop);
  assign w_drop  = push_q && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= rec_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_drop) ovf_q <= 1'b1;
      if (w_push && !w_pop)      count_q <= count_q + 1'b1;
      else if (!w_push && w_pop) count_q <= count_q - 1'b1;
    end
  end

  assign m_valid        = !w_empty;
  assign {m_sat, m_len} = mem_q[rd_ptr_q];
  assign busy           = (state_q == ST_COUNT);
  assign ovf_sticky     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_y_pulse_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_y_pulse_meter : two instances (MIN_LEN 1 and 3) against a pulse-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_y_pulse_meter;

  localparam int DEPTH = 4;
  localparam int LMAX  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       y_in = 1'b1;
  logic       m_ready = 1'b0;
  logic       vld  [2];
  logic [7:0] len  [2];
  logic       sat  [2];
  logic       bsy  [2];
  logic       ovf  [2];

  always #5 clk = ~clk;

  y_pulse_meter #(.CNT_W(8), .FIFO_DEPTH(DEPTH), .MIN_LEN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .y_in(y_in),
    .m_valid(vld[0]), .m_ready(m_ready), .m_len(len[0]), .m_sat(sat[0]),
    .busy(bsy[0]), .ovf_sticky(ovf[0])
  );

  y_pulse_meter #(.CNT_W(8), .FIFO_DEPTH(DEPTH), .MIN_LEN(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .y_in(y_in),
    .m_valid(vld[1]), .m_ready(m_ready), .m_len(len[1]), .m_sat(sat[1]),
    .busy(bsy[1]), .ovf_sticky(ovf[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a pulse is a run of high samples; it is measured only once a real
  // low sample has been seen since reset/clr. Records are sat*256 + len.
  int minl [2] = '{1, 3};
  bit armed   [2];
  bit inpulse [2];
  int run     [2];
  bit pend    [2];
  int pend_rec[2];
  int fq      [2][$];
  bit movf    [2];
  bit prev_y;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 0; inpulse[i] = 0; run[i] = 0; pend[i] = 0;
      fq[i].delete(); movf[i] = 0;
    end
    prev_y = 1'b1;
  endtask

  task automatic model_edge(input bit c, input bit y, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        fq[i].delete(); movf[i] = 0; pend[i] = 0; armed[i] = 0; inpulse[i] = 0;
      end else begin
        int  pre;
        bit  popped;
        pre    = fq[i].size();
        popped = (pre != 0) && rdy;
        if (popped) void'(fq[i].pop_front());
        if (pend[i]) begin
          if (pre < DEPTH || popped) fq[i].push_back(pend_rec[i]);
          else movf[i] = 1;
        end
        pend[i] = 0;
        if (!armed[i]) begin
          if (!prev_y) armed[i] = 1;
        end else if (!inpulse[i]) begin
          if (prev_y) begin inpulse[i] = 1; run[i] = 1; end
        end else if (prev_y) begin
          run[i]++;
        end else begin
          inpulse[i] = 0;
          if (run[i] >= minl[i]) begin
            pend[i]     = 1;
            pend_rec[i] = (run[i] > LMAX) ? (256 + LMAX) : run[i];
          end
        end
      end
    end
    prev_y = y;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid%0d", i), vld[i], int'(fq[i].size() != 0));
      if (fq[i].size() != 0) begin
        check($sformatf("len%0d", i), len[i], fq[i][0] % 256);
        check($sformatf("sat%0d", i), sat[i], fq[i][0] / 256);
      end
      check($sformatf("busy%0d", i), bsy[i], int'(inpulse[i]));
      check($sformatf("ovf%0d", i), ovf[i], int'(movf[i]));
    end
  endtask

  // Called at a falling edge; ends at the next falling edge after checking.
  task automatic step(input bit y, input bit rdy, input bit c);
    y_in = y; m_ready = rdy; clr = c;
    @(posedge clk);
    model_edge(c, y, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(input int hi, input int lo, input bit rdy);
    repeat (hi) step(1'b1, rdy, 1'b0);
    repeat (lo) step(1'b0, rdy, 1'b0);
  endtask

  task automatic reset_zero_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_valid"}, vld[i], 0);
      check({tag, "_len"},   len[i], 0);
      check({tag, "_sat"},   sat[i], 0);
      check({tag, "_busy"},  bsy[i], 0);
      check({tag, "_ovf"},   ovf[i], 0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 reset_zero_checks("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_zero_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Pulse already high at reset release is ignored.
    pulse(5, 2, 1'b0);
    pulse(3, 6, 1'b0);
    check("t1_valid", vld[0], 1);
    check("t1_len", len[0], 3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_single", vld[0], 0);

    // Back-to-back short pulses with single-cycle gaps.
    pulse(1, 1, 1'b1);
    pulse(4, 1, 1'b1);
    pulse(2, 4, 1'b1);

    // Saturation boundary.
    pulse(255, 3, 1'b0);
    check("t3_len255", len[0], 255);
    check("t3_sat255", sat[0], 0);
    step(1'b0, 1'b1, 1'b0);
    pulse(300, 3, 1'b0);
    check("t3_len300", len[0], 255);
    check("t3_sat300", sat[0], 1);
    step(1'b0, 1'b1, 1'b0);

    // Overflow with consumer stalled, then drain.
    step(1'b0, 1'b0, 1'b1);
    repeat (5) pulse(2, 1, 1'b0);
    pulse(0, 2, 1'b0);
    check("t4_ovf", ovf[0], 1);
    check("t4_ovf_min3", ovf[1], 0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("t4_drained", vld[0], 0);

    // Push into a full FIFO in the same cycle as a pop.
    step(1'b0, 1'b0, 1'b1);
    repeat (4) pulse(3, 1, 1'b0);
    pulse(0, 2, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t5_ovf", ovf[0], 0);
    repeat (5) step(1'b0, 1'b1, 1'b0);

    // clr mid-pulse with records queued.
    repeat (2) pulse(3, 1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t6_clr_valid", vld[0], 0);
    check("t6_clr_ovf", ovf[0], 0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    pulse(0, 4, 1'b0);
    check("t6_no_partial", vld[0], 0);

    // Asynchronous reset mid-pulse with records queued.
    repeat (2) pulse(3, 1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0);
    pulse(0, 4, 1'b0);
    check("t6_rst_no_partial", vld[0], 0);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      int hl;
      int ll;
      hl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 6));
      ll = int'($urandom_range(1, 4));
      repeat (hl) step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 80) == 0);
      repeat (ll) step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 80) == 0);
      if (k == 30) do_reset();
    end
    repeat (8) step(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y_pulse_meter.md
Name: y_pulse_meter

Overview:
- Downstream consumer of the sequence detector's 1-bit output Y, fed on y_in in the same clk domain.
- Measures the length in clk cycles of every high pulse on y_in.
- Queues each {saturated, length} record in a small first-word-fall-through FIFO.
- Delivers records to a host or logger over a valid/ready interface; flags drops on overflow.

Parameters:
- CNT_W, 8, width of the pulse-length field. Maximum representable length is 2^CNT_W-1.
- FIFO_DEPTH, 4, number of record entries. Must be a power of 2, ≥2.
- MIN_LEN, 1, pulses shorter than this are discarded silently. Range 1..2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear: flush FIFO, FSM to ARM, clear ovf_sticky
- y_in  in  1  Y from the sequence detector, synchronous to clk
- m_valid  out  1  FIFO head holds a record
- m_ready  in  1  consumer accepts the head this cycle
- m_len  out  CNT_W  head record pulse length
- m_sat  out  1  head record length saturated
- busy  out  1  FSM in COUNT
- ovf_sticky  out  1  at least one record dropped because the FIFO was full

Behaviour:
- Reset values:
  - all outputs 0
  - FIFO empty, rd/wr pointers 0
  - y_q 0, cnt 0, sat 0
  - FSM in ARM
- Input register: y_in is sampled into y_q every edge. The FSM acts only on y_q (one-cycle input latency).
- FSM states:
  - ARM: ignores pulses in progress at reset/clr. y_q=0 → IDLE, else stay.
  - IDLE: y_q=1 → COUNT, cnt<=1, sat<=0. Otherwise stay.
  - COUNT, y_q=1: if cnt==2^CNT_W-1, hold cnt and set sat<=1; otherwise cnt<=cnt+1.
  - COUNT, y_q=0: end of pulse; issue push request of {sat,cnt} if sat=1 or cnt≥MIN_LEN; go to IDLE.
- Length rule:
  - N consecutive high samples give cnt=N.
  - For N>2^CNT_W-1: m_len=2^CNT_W-1 and m_sat=1.
  - For N=2^CNT_W-1 exactly: m_sat=0.
- Timing: if the first low sample of y_in after a pulse is taken at edge E, the record is written at edge E+2. m_valid is high after edge E+2 when the FIFO was empty.
- A single-cycle low gap between two pulses yields two separate records. The next pulse's first high sample enters COUNT from IDLE one edge later, so no cycle is lost.
- FIFO (first-word fall-through):
  - m_valid = !empty; m_len/m_sat reflect the head combinationally from storage.
  - Pop when m_valid && m_ready.
  - m_len/m_sat are stable while m_valid=1 and m_ready=0.
- Push when full:
  - with a pop in the same cycle: push succeeds, occupancy unchanged.
  - without a pop: record dropped, ovf_sticky<=1, FIFO contents unchanged.
- Empty FIFO with m_ready=1: no pop and no pointer change. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Occupancy counter width: log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- clr, priority over all other activity in that cycle:
  - FIFO emptied, FSM to ARM, cnt/sat cleared, ovf_sticky cleared
  - any push or pop in that cycle is discarded
  - y_q is still updated
- rst_n asserted mid-pulse or mid-transfer: immediate return to reset values. The partial pulse is never reported; ARM requires a low sample first.
- busy = (state==COUNT).

Test Plan:
- Reset released with y_in=1 for 5 cycles, then 2 low, then 3 high, then low → exactly one record: m_len=3, m_sat=0. No record for the 5-cycle pulse.
- m_ready=1 throughout; pulses of 1, 4 and 2 cycles separated by single low cycles → records 1, 4, 2 in order; each m_valid appears 2 edges after the pulse's first low sample.
- CNT_W=8; pulse of 255 cycles → m_len=255, m_sat=0. Pulse of 300 cycles → m_len=255, m_sat=1.
- m_ready=0; five 2-cycle pulses → m_valid=1 and ovf_sticky=1 after the 5th. Raise m_ready → exactly four records of length 2 drain, then m_valid=0.
- FIFO full and m_ready=1 in the cycle a 6-cycle pulse's record is pushed → oldest record popped, new record stored, ovf_sticky unchanged. Also with MIN_LEN=3, a 2-cycle pulse → no record and no ovf.
- clr asserted mid-pulse with 2 records queued → m_valid=0 and ovf_sticky=0 next cycle; that pulse is not reported. Repeat using rst_n → all outputs 0 asynchronously.
